// File: rtl/cpu_pkg.sv
// Shared pipeline-control types and defaults for the RV32I core.
package cpu_pkg;

    localparam int DEF_D_WIDTH = 32;
    localparam int DEF_N_REGS  = 32;
    localparam int DEF_RF_SIZE = $clog2(DEF_N_REGS);

    // Data-memory wait controller states
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

    // Operand forwarding source codes
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_WB    = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding source select for one EX-stage operand.
module fwd_sel
    import cpu_pkg::*;
#(
    parameter int RF_SIZE = DEF_RF_SIZE
) (
    input  logic [RF_SIZE-1:0] rs,
    input  logic [RF_SIZE-1:0] exmem_rd,
    input  logic               exmem_reg_write,
    input  logic               exmem_mem_re,
    input  logic [RF_SIZE-1:0] memwb_rd,
    input  logic               memwb_reg_write,
    output logic [1:0]         sel
);

    // Youngest producer wins; a load in EX/MEM has no data yet, so fall through to WB
    always_comb begin
        sel = FWD_RF;
        if (exmem_reg_write && !exmem_mem_re && (exmem_rd != '0) && (exmem_rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard, forwarding and stall controller for the 5-stage RV32I pipeline.
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int D_WIDTH     = DEF_D_WIDTH,
    parameter int N_REGS      = DEF_N_REGS,
    parameter int RF_SIZE     = $clog2(N_REGS),
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RF_SIZE-1:0]   ifid_rs1,
    input  logic [RF_SIZE-1:0]   ifid_rs2,
    input  logic                 ifid_uses_rs1,
    input  logic                 ifid_uses_rs2,
    input  logic [RF_SIZE-1:0]   idex_rs1,
    input  logic [RF_SIZE-1:0]   idex_rs2,
    input  logic [RF_SIZE-1:0]   idex_rd,
    input  logic                 idex_reg_write,
    input  logic                 idex_mem_re,
    input  logic [RF_SIZE-1:0]   exmem_rd,
    input  logic                 exmem_reg_write,
    input  logic                 exmem_mem_re,
    input  logic                 exmem_mem_req,
    input  logic [RF_SIZE-1:0]   memwb_rd,
    input  logic                 memwb_reg_write,
    input  logic                 branch_taken_ex,
    input  logic                 dmem_ready,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 exmem_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 memwb_bubble,
    output logic                 pc_sel,
    output logic [1:0]           fwd_a_sel,
    output logic [1:0]           fwd_b_sel,
    output logic                 mem_timeout,
    output logic                 err_sticky,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    if (MEM_TIMEOUT < 1) begin : g_bad_timeout
        $error("pipe_ctrl: MEM_TIMEOUT must be at least 1");
    end
    if (CNT_WIDTH > D_WIDTH) begin : g_bad_cnt_width
        $error("pipe_ctrl: CNT_WIDTH must not exceed D_WIDTH");
    end

    // A load in EX always writes rd, so its write enable adds nothing to the hazard check
    logic unused_idex_reg_write;
    assign unused_idex_reg_write = idex_reg_write;

    ctrl_state_t       state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic              freeze;
    logic              load_use;
    logic [1:0]        fwd_a_raw, fwd_b_raw;

    fwd_sel #(.RF_SIZE(RF_SIZE)) u_fwd_a (
        .rs              (idex_rs1),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_mem_re    (exmem_mem_re),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .sel             (fwd_a_raw)
    );

    fwd_sel #(.RF_SIZE(RF_SIZE)) u_fwd_b (
        .rs              (idex_rs2),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_mem_re    (exmem_mem_re),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .sel             (fwd_b_raw)
    );

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        load_use = idex_mem_re && (idex_rd != '0) &&
                   ((ifid_uses_rs1 && (ifid_rs1 == idex_rd)) ||
                    (ifid_uses_rs2 && (ifid_rs2 == idex_rd)));
    end

    // Memory-wait state register and wait counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
        end
    end

    // Next state, freeze/timeout decision and stage controls by priority
    always_comb begin
        state_nx     = state;
        wait_nx      = wait_cnt;
        freeze       = 1'b0;
        mem_timeout  = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        pc_sel       = 1'b0;
        fwd_a_sel    = fwd_a_raw;
        fwd_b_sel    = fwd_b_raw;

        case (state)
            RUN: begin
                if (exmem_mem_req && !dmem_ready) begin
                    freeze   = 1'b1;
                    wait_nx  = WAIT_W'(1);
                    state_nx = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    wait_nx  = '0;
                    state_nx = RUN;
                end else if (wait_cnt == WAIT_MAX) begin
                    mem_timeout = 1'b1;
                    wait_nx     = '0;
                    state_nx    = RUN;
                end else begin
                    freeze  = 1'b1;
                    wait_nx = wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                wait_nx  = '0;
                state_nx = RUN;
            end
        endcase

        if (!rst) begin
            mem_timeout  = 1'b0;
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
            fwd_a_sel    = FWD_RF;
            fwd_b_sel    = FWD_RF;
        end else if (freeze) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (branch_taken_ex) begin
            pc_sel     = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Saturating perf counters and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (!pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (pc_sel && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
            end
            if (mem_timeout) begin
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Centralised hazard, forwarding and stall controller for the 5-stage RV32I pipeline. It replaces the inline load-use and forwarding logic in the CPU top level and adds four behaviours: taken-branch flush from EX, a real bubble on load-use, a variable-latency data-memory wait FSM with timeout, and saturating performance counters. It is parametrised in data width, register count, memory timeout and counter width.

## Interface
- D_WIDTH, 32, datapath width (forwarded data is muxed outside; used for counter checks only)
- N_REGS, 32, architectural register count
- RF_SIZE, $clog2(N_REGS), register index width
- MEM_TIMEOUT, 15, max wait cycles on a data-memory request before abort (≥1)
- CNT_WIDTH, 16, perf counter width
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-low reset
- ifid_rs1, ifid_rs2  in  RF_SIZE  source indices of the instruction in ID
- ifid_uses_rs1, ifid_uses_rs2  in  1  ID instruction actually reads that source
- idex_rs1, idex_rs2, idex_rd  in  RF_SIZE  EX-stage indices
- idex_reg_write, idex_mem_re  in  1  EX-stage control
- exmem_rd  in  RF_SIZE; exmem_reg_write, exmem_mem_re, exmem_mem_req  in  1  MEM-stage control (mem_req = re|we)
- memwb_rd  in  RF_SIZE; memwb_reg_write  in  1  WB-stage control
- branch_taken_ex  in  1  EX resolved a taken branch/jump
- dmem_ready  in  1  data memory completes the MEM-stage request this cycle
- pc_en, ifid_en, idex_en, exmem_en  out  1  stage register enables
- ifid_flush, idex_flush, memwb_bubble  out  1  load NOP/zero control into that register
- pc_sel  out  1  1 = PC loads branch target
- fwd_a_sel, fwd_b_sel  out  2  00 regfile, 01 EX/MEM alu_out, 10 WB data
- mem_timeout  out  1  one-cycle pulse on abort
- err_sticky  out  1  set by any timeout, cleared only by reset
- stall_cnt, flush_cnt  out  CNT_WIDTH  perf counters

## Operation
- Forwarding (per operand, combinational): EX/MEM wins if exmem_reg_write & ~exmem_mem_re & exmem_rd≠0 & exmem_rd==idex_rsX; else WB if memwb_reg_write & memwb_rd≠0 & match; else 00.
- Load-use: idex_mem_re & idex_rd≠0 & ((uses_rs1 & rs1==idex_rd) | (uses_rs2 & rs2==idex_rd)) → pc_en=0, ifid_en=0, idex_flush=1; EX/MEM, MEM/WB advance.
- Branch: branch_taken_ex → pc_sel=1, pc_en=1, ifid_flush=1, idex_flush=1 (two younger instructions squashed).
- Memory freeze: pc_en=ifid_en=idex_en=exmem_en=0, memwb_bubble=1, no flush.
- Priority: freeze > branch > load-use > normal. A branch in EX during a freeze is held (EX frozen) and is acted on in the first unfrozen cycle.
- FSM states: RUN, MEM_WAIT. Transitions:
  - RUN: exmem_mem_req & ~dmem_ready → freeze, wait_cnt←1, go MEM_WAIT. Ready in the same cycle → no stall.
  - MEM_WAIT: dmem_ready → unfreeze this cycle, wait_cnt←0, go RUN. Otherwise, wait_cnt==MEM_TIMEOUT → mem_timeout=1, err_sticky←1, unfreeze (read data undefined), go RUN. Otherwise freeze, wait_cnt++.
- Counters: stall_cnt +1 every non-reset cycle with pc_en=0; flush_cnt +1 per cycle with pc_sel=1. Both saturate at all-ones.

## Timing
- Reset (rst=0 at edge): state RUN, wait_cnt, stall_cnt, flush_cnt and err_sticky all 0.
- While rst=0, outputs are forced: all enables 0, ifid_flush=idex_flush=memwb_bubble=1, pc_sel=0, fwd 00, mem_timeout=0.
- All outputs except counters and err_sticky are combinational from inputs and state, with zero latency.
- Load-use costs exactly 1 cycle; taken branch costs 2 cycles; a memory wait of N cycles costs N freeze cycles, capped at MEM_TIMEOUT.
- Reset mid-MEM_WAIT aborts silently: no mem_timeout pulse.

## Structure
- Shared package cpu_pkg holds:
  - state enum (RUN, MEM_WAIT)
  - fwd codes FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_WB=2'b10
  - RF_SIZE/D_WIDTH defaults
- Sub-module fwd_sel: combinational, one per operand, instantiated twice.

## Test plan
- x1 written at EX/MEM, x1 also at WB, idex_rs1=1 → fwd_a_sel=01; with EX/MEM rd=0 → 10.
- lw x5 in EX, add using x5 in ID → one cycle with pc_en=0, idex_flush=1; forwarding selects 10 in the next cycle; stall_cnt=1.
- branch_taken_ex=1 with a load-use condition present → pc_sel=1, both flushes, no stall; flush_cnt=1.
- exmem_mem_req=1, dmem_ready low 3 cycles → 3 freeze cycles, memwb_bubble=1; resumes on cycle 4; stall_cnt=3.
- MEM_TIMEOUT=4, dmem_ready never → mem_timeout pulses at cycle 5, err_sticky=1 until rst=0.
- rst=0 during MEM_WAIT → next cycle in RUN, counters 0, no timeout pulse.
